// File: rtl/lifo_frame_reverser.sv
// lifo_frame_reverser: pushes framed bytes into an external LIFO and drains them reversed,
// one DEPTH-sized chunk at a time, with valid/ready on both sides.
module lifo_frame_reverser #(
    parameter int DW    = 8,
    parameter int DEPTH = 8,
    parameter int CW    = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    input  logic          in_last,
    output logic          in_ready,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    output logic          out_last,
    input  logic          out_ready,
    output logic          lifo_wn,
    output logic          lifo_rn,
    output logic [DW-1:0] lifo_din,
    input  logic [DW-1:0] lifo_dout,
    input  logic          lifo_full,
    input  logic          lifo_empty,
    output logic          busy,
    output logic          err
);
    typedef enum logic [1:0] {FILL, POP, WAIT, HOLD} state_t;

    state_t        r_state, w_next;
    logic [CW-1:0] r_cnt;
    logic          r_last_seen, r_rn, r_err, r_out_valid, r_out_last;
    logic [DW-1:0] r_out_data;
    logic          w_accept, w_push, w_pop_err, w_out_hs;

    assign in_ready  = (r_state == FILL) && (r_cnt < CW'(DEPTH));
    assign w_accept  = in_valid && in_ready;
    assign w_push    = w_accept && !lifo_full;
    assign w_pop_err = (r_state == POP) && lifo_empty;
    assign w_out_hs  = (r_state == HOLD) && r_out_valid && out_ready;
    assign lifo_wn   = w_push;
    assign lifo_din  = w_push ? in_data : '0;
    // The pop strobe is registered; an empty stack only masks it.
    assign lifo_rn   = r_rn && !lifo_empty;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign err       = r_err;
    assign busy      = (r_state != FILL) || (r_cnt != '0);

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            FILL: if (w_push && (in_last || (r_cnt + CW'(1)) == CW'(DEPTH))) w_next = POP;
            POP:  w_next = lifo_empty ? FILL : WAIT;
            WAIT: w_next = HOLD;
            HOLD: if (w_out_hs) w_next = (r_cnt == CW'(1)) ? FILL : POP;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= FILL;
            r_cnt       <= '0;
            r_last_seen <= 1'b0;
            r_rn        <= 1'b0;
            r_err       <= 1'b0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_rn    <= (w_next == POP);
            if ((w_accept && lifo_full) || w_pop_err) r_err <= 1'b1;
            if (w_push) begin
                r_cnt       <= r_cnt + CW'(1);
                r_last_seen <= in_last;
            end
            if (w_pop_err) begin
                r_cnt       <= '0;
                r_last_seen <= 1'b0;
            end
            if (r_state == WAIT) begin
                r_out_data  <= lifo_dout;
                r_out_valid <= 1'b1;
                r_out_last  <= r_last_seen && (r_cnt == CW'(1));
            end
            if (w_out_hs) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
                r_cnt       <= r_cnt - CW'(1);
                if (r_cnt == CW'(1)) r_last_seen <= 1'b0;
            end
        end
    end
endmodule

// File: doc/lifo_frame_reverser.md
Name: lifo_frame_reverser

Overview:
- Upstream controller for the 8x8 linear stack (LIFO) block.
- Accepts a valid/ready byte stream framed by a last flag and pushes each byte into the stack.
- On frame end or stack full, it pops the stack and emits the bytes downstream in reversed order, with its own valid/ready handshake.
- Drives the stack's wn/rn/DATAIN and consumes its DATAOUT/full/empty.

Parameters:
DW, 8, data width in bits (must match stack width)
DEPTH, 8, stack capacity in entries (must match stack size)
CW, 4, occupancy counter width; must hold DEPTH

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
in_data  input  DW  upstream byte
in_valid  input  1  upstream byte valid
in_last  input  1  byte is last of frame
in_ready  output  1  block can accept a byte
out_data  output  DW  reversed byte to downstream
out_valid  output  1  out_data valid
out_last  output  1  final byte of a reversed frame
out_ready  input  1  downstream accepts
lifo_wn  output  1  push strobe to stack
lifo_rn  output  1  pop strobe to stack
lifo_din  output  DW  data to stack
lifo_dout  input  DW  stack registered read data
lifo_full  input  1  stack full
lifo_empty  input  1  stack empty
busy  output  1  state is not FILL or cnt != 0
err  output  1  sticky protocol error

Behaviour:
- Reset is synchronous and active-high on posedge clock, with a single clock domain.
- Reset values:
  - state=FILL, cnt=0, last_seen=0.
  - out_data=0, out_valid=0, out_last=0.
  - lifo_rn=0, err=0.
  - in_ready=1 from the first cycle after reset is released.
- Reset mid-frame discards all state. The stack is reset by the same reset.
- cnt (CW bits) is the controller's own occupancy count. Stack full/empty flags are used only for error checking, never for sequencing.
- FILL state:
  - in_ready = (cnt < DEPTH).
  - Acceptance occurs when in_valid & in_ready.
  - lifo_wn = acceptance (combinational) and lifo_din = in_data. Both are 0 otherwise.
  - On acceptance: cnt <= cnt+1 and last_seen <= in_last.
  - Go to POP when in_last=1 on acceptance, or when cnt+1 == DEPTH.
- POP state:
  - lifo_rn=1 for exactly one cycle (registered). in_ready=0.
  - Next state is WAIT.
  - If lifo_empty=1 in POP: set err, suppress the pop, force cnt to 0, go to FILL, and emit no output.
- WAIT state:
  - The stack's registered DATAOUT is valid in this cycle.
  - out_data <= lifo_dout and out_valid <= 1.
  - out_last <= last_seen & (cnt == 1).
  - Go to HOLD.
- HOLD state:
  - out_data, out_valid and out_last are held stable while out_ready=0.
  - On out_valid & out_ready: out_valid <= 0, out_last <= 0, cnt <= cnt-1.
  - Then go to FILL if cnt == 1 (also clear last_seen), else go to POP.
- Latency:
  - From lifo_rn assertion to out_valid is 2 cycles.
  - Drain throughput is 1 byte per 3 cycles when out_ready is held high.
- Split frames: a frame longer than DEPTH is emitted as reversed DEPTH-sized chunks. out_last is asserted only on the final byte of the chunk containing in_last.
- lifo_wn and lifo_rn are never high in the same cycle. No push occurs outside FILL.
- err also sets if lifo_wn would assert while lifo_full=1; that push is suppressed and cnt is unchanged.
- err is cleared only by reset.
- busy = (state != FILL) | (cnt != 0).

Test Plan:
1. Reset, then push frame 0x11,0x22,0x33 (last on 0x33) with out_ready=1 -> out emits 0x33,0x22,0x11; out_last only on 0x11; in_ready=0 during drain; busy falls after the 0x11 handshake.
2. Push 10 bytes 0x01..0x0A (last on 0x0A) -> in_ready drops after 0x08; out emits 0x08..0x01 with out_last=0 throughout; then accepts 0x09,0x0A; out emits 0x0A,0x09 with out_last on 0x09.
3. Single-byte frame 0x5A with last, and out_ready held low for 5 cycles -> out_valid=1 with out_data=0x5A and out_last=1, stable all 5 cycles; accepted on the first out_ready cycle.
4. Assert reset mid-drain of a 4-byte frame -> next cycle out_valid=0, cnt=0, in_ready=1; a new frame 0xA0,0xB0 comes out as 0xB0,0xA0.
5. Force lifo_full=1 during FILL with in_valid=1 -> lifo_wn stays 0, err=1 sticky, cnt unchanged; force lifo_empty=1 in POP -> lifo_rn stays 0 and state returns to FILL.
6. Random in_valid/out_ready back-pressure over 200 frames of length 1..20 -> output equals the chunk-wise reversed scoreboard, and lifo_wn & lifo_rn is never both 1.
